// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and CTRL.
// Contents:
//   PC_W, INSTR_W, CNT_W : default widths for PC, instruction word and retire counter
//   fetch_state_t        : fetch-stage run state (IDLE / RUN / DONE)
//   OPC_END, OPC_LRV     : opcode values that both fetch and CTRL rely on
package cpu_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // The upper four bits of an instruction word hold the opcode. An all-zero
  // word decodes as "end", which is why fetch drives zeros when not running.
  localparam logic [3:0] OPC_END = 4'b0000;
  localparam logic [3:0] OPC_LRV = 4'b0001;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc            in  current program counter
//   pc_inc2       in  current instruction occupies two words
//   pc_bns/pc_bcz in  branch-on-sign / branch-on-zero requests from CTRL
//   sign_flag     in  sign status
//   zero_flag     in  zero status
//   branch_target in  absolute branch destination
//   pc_inc1       out pc + 1 (immediate-word address)
//   pc_nxt        out PC to load when CTRL advances
// All sums wrap modulo 2^PC_W.
module pc_next #(
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic            pc_inc2,
  input  logic            pc_bns,
  input  logic            pc_bcz,
  input  logic            sign_flag,
  input  logic            zero_flag,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc_inc1,
  output logic [PC_W-1:0] pc_nxt
);

  import cpu_pkg::*;

  logic            taken;
  logic [PC_W-1:0] pc_seq;

  assign pc_inc1 = pc + PC_W'(1);
  assign pc_seq  = pc + (pc_inc2 ? PC_W'(2) : PC_W'(1));

  // Both branch kinds may be requested together; either condition takes it.
  assign taken  = (pc_bns & sign_flag) | (pc_bcz & zero_flag);

  // A taken branch wins over the two-word increment.
  assign pc_nxt = taken ? branch_target : pc_seq;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch / program-counter stage in front of CTRL.
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   start                host run request (also CTRL req)
//   ack                  CTRL idle/finished
//   pc_update, pc_inc2   CTRL advance request, two-word instruction
//   pc_bns, pc_bcz       CTRL conditional branch requests
//   sign_flag, zero_flag branch conditions
//   branch_target        absolute branch destination
//   imem_addr            ROM address (= pc)
//   imem_addr_nxt        pc + 1, address of an lrv immediate word
//   imem_rdata           ROM data at imem_addr, combinational
//   instruction          word presented to CTRL (zero unless running)
//   pc                   current program counter
//   running, done        state == RUN / state == DONE
//   instr_count          instructions retired since the last start (saturating)
module pc_fetch #(
  parameter int                     PC_W       = cpu_pkg::PC_W,
  parameter int                     INSTR_W    = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0]        START_ADDR = '0,
  parameter int                     CNT_W      = cpu_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ack,
  input  logic               pc_update,
  input  logic               pc_inc2,
  input  logic               pc_bns,
  input  logic               pc_bcz,
  input  logic               sign_flag,
  input  logic               zero_flag,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  output logic [PC_W-1:0]    imem_addr_nxt,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic               running,
  output logic               done,
  output logic [CNT_W-1:0]   instr_count
);

  import cpu_pkg::*;

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_nxt, pc_inc1;
  logic [CNT_W-1:0] cnt_q;
  logic             load_start;
  logic             advance;

  pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc            (pc_q),
    .pc_inc2       (pc_inc2),
    .pc_bns        (pc_bns),
    .pc_bcz        (pc_bcz),
    .sign_flag     (sign_flag),
    .zero_flag     (zero_flag),
    .branch_target (branch_target),
    .pc_inc1       (pc_inc1),
    .pc_nxt        (pc_nxt)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    advance    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          load_start = 1'b1;
        end
      end
      RUN: begin
        // start is deliberately ignored here: no restart while running.
        if (pc_update) begin
          advance = 1'b1;
        end else if (ack) begin
          state_d = DONE;
        end
        // pc_update=0 and ack=0 is a CTRL stall: everything holds.
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_start) begin
        pc_q  <= START_ADDR;
        cnt_q <= '0;
      end else if (advance) begin
        pc_q <= pc_nxt;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign running       = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pc            = pc_q;
  assign imem_addr     = pc_q;
  assign imem_addr_nxt = pc_inc1;
  assign instr_count   = cnt_q;

  // Outside RUN CTRL must see the end opcode so it stays idle.
  assign instruction   = running ? imem_rdata : {INSTR_W{1'b0}};

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch. A behavioural model predicts the state,
// PC and retire count for every driven cycle; predictions are queued when the
// stimulus is applied and popped and compared once the DUT has clocked it.
module tb_pc_fetch;

  import cpu_pkg::*;

  typedef struct {
    logic [9:0]  pc;
    logic [15:0] cnt;
    logic        running;
    logic        done;
    logic [8:0]  instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start, ack, pc_update, pc_inc2, pc_bns, pc_bcz;
  logic        sign_flag, zero_flag;
  logic [9:0]  branch_target;
  logic [9:0]  imem_addr, imem_addr_nxt, pc;
  logic [8:0]  imem_rdata, instruction;
  logic        running, done;
  logic [15:0] instr_count;

  logic [8:0]  rom [1024];
  exp_t        sb [$];

  fetch_state_t m_state;
  logic [9:0]   m_pc;
  logic [15:0]  m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pc_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ack           (ack),
    .pc_update     (pc_update),
    .pc_inc2       (pc_inc2),
    .pc_bns        (pc_bns),
    .pc_bcz        (pc_bcz),
    .sign_flag     (sign_flag),
    .zero_flag     (zero_flag),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_addr_nxt (imem_addr_nxt),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc            (pc),
    .running       (running),
    .done          (done),
    .instr_count   (instr_count)
  );

  assign imem_rdata = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of stimulus, predict its effect, queue the prediction,
  // then advance to just after the rising edge.
  task automatic drive(input logic upd, input logic inc2, input logic bns,
                       input logic bcz, input logic s, input logic z,
                       input logic [9:0] tgt, input logic ak, input logic st);
    exp_t e;
    logic tk;
    pc_update = upd; pc_inc2 = inc2; pc_bns = bns; pc_bcz = bcz;
    sign_flag = s; zero_flag = z; branch_target = tgt; ack = ak; start = st;
    case (m_state)
      IDLE, DONE: if (st) begin m_state = RUN; m_pc = 10'd0; m_cnt = 16'd0; end
      RUN: begin
        if (upd) begin
          tk = (bns && s) || (bcz && z);
          m_pc = tk ? tgt : m_pc + (inc2 ? 10'd2 : 10'd1);
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (ak) begin
          m_state = DONE;
        end
      end
      default: ;
    endcase
    e.pc      = m_pc;
    e.cnt     = m_cnt;
    e.running = (m_state == RUN);
    e.done    = (m_state == DONE);
    e.instr   = (m_state == RUN) ? rom[m_pc] : 9'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (pc !== 10'd0) $display("FAIL reset_pc: got %h expected 000", pc); else n_pass++;
    n_checks++; if (instr_count !== 16'd0) $display("FAIL reset_cnt: got %h expected 0000", instr_count); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL reset_running: got %b expected 0", running); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (instruction !== 9'd0) $display("FAIL reset_instr: got %h expected 000", instruction); else n_pass++;
    n_checks++; if (imem_addr_nxt !== 10'd1) $display("FAIL reset_addr_nxt: got %h expected 001", imem_addr_nxt); else n_pass++;
  endtask

  task automatic test_sequential();
    exp_t e;
    drive(0, 0, 0, 0, 0, 0, 10'd0, 0, 1);
    e = sb.pop_front();
    n_checks++; if (running !== e.running) $display("FAIL start_running: got %b expected %b", running, e.running); else n_pass++;
    n_checks++; if (pc !== e.pc) $display("FAIL start_pc: got %h expected %h", pc, e.pc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 10'd0, 0, 0);
      e = sb.pop_front();
      n_checks++; if (pc !== e.pc) $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, e.pc); else n_pass++;
      n_checks++; if (instruction !== e.instr) $display("FAIL seq_instr[%0d]: got %h expected %h", i, instruction, e.instr); else n_pass++;
    end
    n_checks++; if (instr_count !== 16'd4) $display("FAIL seq_cnt: got %0d expected 4", instr_count); else n_pass++;
  endtask

  task automatic test_lrv();
    exp_t e;
    drive(1, 0, 0, 0, 0, 0, 10'd0, 0, 0);
    e = sb.pop_front();
    n_checks++; if (pc !== 10'd5) $display("FAIL lrv_pc_at: got %h expected 005", pc); else n_pass++;
    n_checks++; if (imem_addr_nxt !== 10'd6) $display("FAIL lrv_addr_nxt: got %h expected 006", imem_addr_nxt); else n_pass++;
    n_checks++; if (instruction !== e.instr) $display("FAIL lrv_instr: got %h expected %h", instruction, e.instr); else n_pass++;
    drive(1, 1, 0, 0, 0, 0, 10'd0, 0, 0);
    e = sb.pop_front();
    n_checks++; if (pc !== e.pc) $display("FAIL lrv_next_pc: got %h expected %h", pc, e.pc); else n_pass++;
  endtask

  task automatic test_branch();
    // {bns, bcz, sign, zero, inc2, target}
    logic [14:0] tbl [5];
    exp_t e;
    tbl[0] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0A0};  // bns taken
    tbl[1] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0A0};  // bns not taken
    tbl[2] = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'h123};  // bcz taken beats inc2
    tbl[3] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h200};  // both, only zero holds
    tbl[4] = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'h3C0};  // bcz not taken, inc2
    for (int i = 0; i < 5; i++) begin
      drive(1, tbl[i][10], tbl[i][14], tbl[i][13], tbl[i][12], tbl[i][11], tbl[i][9:0], 0, 0);
      e = sb.pop_front();
      n_checks++; if (pc !== e.pc) $display("FAIL branch_pc[%0d]: got %h expected %h", i, pc, e.pc); else n_pass++;
      n_checks++; if (instr_count !== e.cnt) $display("FAIL branch_cnt[%0d]: got %0d expected %0d", i, instr_count, e.cnt); else n_pass++;
    end
  endtask

  task automatic test_stall();
    exp_t e;
    // start held high while running must not restart.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1, 1, 1, 10'h055, 0, 1);
      e = sb.pop_front();
      n_checks++; if (pc !== e.pc) $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, e.pc); else n_pass++;
      n_checks++; if (instr_count !== e.cnt) $display("FAIL stall_cnt[%0d]: got %0d expected %0d", i, instr_count, e.cnt); else n_pass++;
      n_checks++; if (running !== 1'b1) $display("FAIL stall_running[%0d]: got %b expected 1", i, running); else n_pass++;
    end
  endtask

  task automatic test_done();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 10'd0, 1, 0);
      e = sb.pop_front();
      n_checks++; if (done !== 1'b1) $display("FAIL done_flag[%0d]: got %b expected 1", i, done); else n_pass++;
      n_checks++; if (running !== 1'b0) $display("FAIL done_running[%0d]: got %b expected 0", i, running); else n_pass++;
      n_checks++; if (instruction !== 9'd0) $display("FAIL done_instr[%0d]: got %h expected 000", i, instruction); else n_pass++;
      n_checks++; if (pc !== e.pc) $display("FAIL done_pc[%0d]: got %h expected %h", i, pc, e.pc); else n_pass++;
      n_checks++; if (instr_count !== e.cnt) $display("FAIL done_cnt[%0d]: got %0d expected %0d", i, instr_count, e.cnt); else n_pass++;
    end
    drive(0, 0, 0, 0, 0, 0, 10'd0, 1, 1);
    e = sb.pop_front();
    n_checks++; if (running !== 1'b1) $display("FAIL restart_running: got %b expected 1", running); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL restart_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (pc !== 10'd0) $display("FAIL restart_pc: got %h expected 000", pc); else n_pass++;
    n_checks++; if (instr_count !== 16'd0) $display("FAIL restart_cnt: got %0d expected 0", instr_count); else n_pass++;
  endtask

  task automatic test_wrap();
    exp_t e;
    drive(1, 0, 1, 0, 1, 0, 10'h3FF, 0, 0);
    e = sb.pop_front();
    n_checks++; if (pc !== 10'h3FF) $display("FAIL wrap_setup_pc: got %h expected 3ff", pc); else n_pass++;
    n_checks++; if (imem_addr_nxt !== 10'h000) $display("FAIL wrap_addr_nxt: got %h expected 000", imem_addr_nxt); else n_pass++;
    drive(1, 0, 0, 0, 0, 0, 10'd0, 0, 0);
    e = sb.pop_front();
    n_checks++; if (pc !== e.pc) $display("FAIL wrap_inc1: got %h expected %h", pc, e.pc); else n_pass++;
    drive(1, 0, 0, 1, 0, 1, 10'h3FF, 0, 0);
    e = sb.pop_front();
    drive(1, 1, 0, 0, 0, 0, 10'd0, 0, 0);
    e = sb.pop_front();
    n_checks++; if (pc !== 10'h001) $display("FAIL wrap_inc2: got %h expected 001", pc); else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 0, 10'd0, 0, 0);
    void'(sb.pop_front());
    #2 reset = 1'b0;
    #1;
    n_checks++; if (pc !== 10'd0) $display("FAIL areset_pc: got %h expected 000", pc); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL areset_running: got %b expected 0", running); else n_pass++;
    n_checks++; if (instruction !== 9'd0) $display("FAIL areset_instr: got %h expected 000", instruction); else n_pass++;
    n_checks++; if (instr_count !== 16'd0) $display("FAIL areset_cnt: got %h expected 0000", instr_count); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_state = IDLE; m_pc = 10'd0; m_cnt = 16'd0;
    sb.delete();
    n_checks++; if (running !== 1'b0) $display("FAIL areset_idle: got %b expected 0", running); else n_pass++;
  endtask

  task automatic test_saturation();
    exp_t e;
    drive(0, 0, 0, 0, 0, 0, 10'd0, 0, 1);
    void'(sb.pop_front());
    for (int i = 0; i < 65535; i++) begin
      drive(1, 0, 0, 0, 0, 0, 10'd0, 0, 0);
      e = sb.pop_front();
    end
    n_checks++; if (instr_count !== 16'hFFFF) $display("FAIL sat_reach: got %h expected ffff", instr_count); else n_pass++;
    n_checks++; if (pc !== e.pc) $display("FAIL sat_pc: got %h expected %h", pc, e.pc); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0, 10'd0, 0, 0);
      e = sb.pop_front();
    end
    n_checks++; if (instr_count !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", instr_count); else n_pass++;
    n_checks++; if (pc !== e.pc) $display("FAIL sat_pc_after: got %h expected %h", pc, e.pc); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'((i * 37 + 11) % 512);
    for (int i = 0; i < 5; i++) rom[i] = 9'b0100_00000;
    rom[5] = 9'b0001_00000;
    rom[6] = 9'h055;

    reset = 1'b0;
    start = 0; ack = 0; pc_update = 0; pc_inc2 = 0; pc_bns = 0; pc_bcz = 0;
    sign_flag = 0; zero_flag = 0; branch_target = '0;
    m_state = IDLE; m_pc = 10'd0; m_cnt = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    test_reset();
    test_sequential();
    test_lrv();
    test_branch();
    test_stall();
    test_done();
    test_wrap();
    test_async_reset();
    test_saturation();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
